// File: rtl/scope_capture.sv
// scope_capture: N-channel triggered capture engine.
// Decimates incoming ADC samples, waits for a level/edge trigger (or an auto
// timeout), and captures a trigger-aligned frame into a ping-pong buffer.
// The renderer reads the front bank by screen X while the back bank fills.
module scope_capture #(
    parameter int CHANNELS     = 2,
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 640,
    parameter int ADDR_W       = 10,
    parameter int DECIM_W      = 16,
    parameter int AUTO_TIMEOUT = 2048
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [CHANNELS*DATA_W-1:0]   ch_data,
    input  logic [2:0]                   trig_channel,
    input  logic [DATA_W-1:0]            trig_level,
    input  logic                         trig_falling,
    input  logic [1:0]                   mode,
    input  logic                         arm,
    input  logic [DECIM_W-1:0]           decim,
    input  logic [ADDR_W-1:0]            pretrig,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [CHANNELS*DATA_W-1:0]   rd_data,
    output logic                         frame_ready,
    output logic                         frame_valid,
    output logic                         triggered,
    output logic                         busy
);

    localparam int                SW      = CHANNELS * DATA_W;
    localparam int                TO_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        MODE_AUTO   = 2'b00;
    localparam logic [1:0]        MODE_SINGLE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Control latched at frame start
    logic [2:0]         cfg_chan;
    logic [DATA_W-1:0]  cfg_level;
    logic               cfg_falling;
    logic [1:0]         cfg_mode;
    logic [DECIM_W-1:0] cfg_decim;
    logic [ADDR_W-1:0]  cfg_pretrig;

    // Capture progress
    logic [DECIM_W-1:0] dec_cnt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W:0]    phase_cnt;
    logic [TO_W-1:0]    armed_cnt;
    logic [DATA_W-1:0]  prev_val;
    logic               prev_ok;
    logic [ADDR_W-1:0]  trig_ptr;
    logic               trig_real;

    // Bank bookkeeping
    logic               front_sel;
    logic [ADDR_W-1:0]  start_front;

    // Combinational helpers
    logic [ADDR_W-1:0]  pretrig_clamped;
    logic [DATA_W-1:0]  cur_sample;
    logic               capturing;
    logic               kept;
    logic               edge_hit;
    logic               auto_hit;
    logic               fire;
    logic               load_cfg;
    logic [ADDR_W:0]    post_need;
    logic [ADDR_W:0]    phase_inc;
    logic [ADDR_W-1:0]  new_start;
    logic               rd_sel;
    logic [ADDR_W-1:0]  rd_start;
    logic [ADDR_W:0]    rd_sum;
    logic [ADDR_W-1:0]  rd_phys;

    logic [SW-1:0]      mem [2][DEPTH];

    assign capturing = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
    assign kept      = capturing && sample_valid && (dec_cnt == '0);
    assign edge_hit  = prev_ok && (cfg_falling ? ((prev_val >= cfg_level) && (cur_sample <  cfg_level))
                                               : ((prev_val <  cfg_level) && (cur_sample >= cfg_level)));
    assign auto_hit  = (cfg_mode == MODE_AUTO) && (armed_cnt == TO_W'(AUTO_TIMEOUT - 1));
    assign fire      = kept && (state == S_ARMED) && (edge_hit || auto_hit);
    assign load_cfg  = ((state == S_IDLE) && arm) || (state == S_DONE);
    assign post_need = DEPTH_L - {1'b0, cfg_pretrig};
    assign phase_inc = phase_cnt + ONE_L;

    assign frame_ready = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    // Clamp the requested pre-trigger depth and pick the trigger channel sample
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pretrig_clamped = pretrig;
        if ({1'b0, pretrig} >= DEPTH_L) begin
            pretrig_clamped = LAST_L;
        end
        cur_sample = ch_data[DATA_W-1:0];
        for (int k = 0; k < CHANNELS; k++) begin
            if (cfg_chan == 3'(k)) begin
                cur_sample = ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Frame start offset (trigger position minus pre-trigger depth, modulo DEPTH)
    always_comb begin
        new_start = trig_ptr - cfg_pretrig;
        if (trig_ptr < cfg_pretrig) begin
            new_start = ADDR_W'({1'b0, trig_ptr} + DEPTH_L - {1'b0, cfg_pretrig});
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (arm) begin
                    state_next = (pretrig_clamped == '0) ? S_ARMED : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (kept && (phase_inc == {1'b0, cfg_pretrig})) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (fire) begin
                    state_next = (post_need == ONE_L) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (kept && (phase_inc == post_need)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (cfg_mode == MODE_SINGLE) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = (pretrig_clamped == '0) ? S_ARMED : S_PREFILL;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control latch, decimation, write pointer, phase counters and trigger history
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_chan    <= '0;
            cfg_level   <= '0;
            cfg_falling <= 1'b0;
            cfg_mode    <= '0;
            cfg_decim   <= '0;
            cfg_pretrig <= '0;
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            phase_cnt   <= '0;
            armed_cnt   <= '0;
            prev_val    <= '0;
            prev_ok     <= 1'b0;
            trig_ptr    <= '0;
            trig_real   <= 1'b0;
        end else begin
            if (load_cfg) begin
                cfg_chan    <= trig_channel;
                cfg_level   <= trig_level;
                cfg_falling <= trig_falling;
                cfg_mode    <= mode;
                cfg_decim   <= decim;
                cfg_pretrig <= pretrig_clamped;
                dec_cnt     <= '0;
                wr_ptr      <= '0;
                prev_ok     <= 1'b0;
            end else begin
                if (capturing && sample_valid) begin
                    dec_cnt <= (dec_cnt == cfg_decim) ? '0 : dec_cnt + DECIM_W'(1);
                end
                if (kept) begin
                    wr_ptr   <= (wr_ptr == LAST_L) ? '0 : wr_ptr + ADDR_W'(1);
                    prev_val <= cur_sample;
                    prev_ok  <= 1'b1;
                end
            end

            // The trigger sample is the first POST sample
            if (fire) begin
                phase_cnt <= ONE_L;
            end else if (state_next != state) begin
                phase_cnt <= '0;
            end else if (kept) begin
                phase_cnt <= phase_inc;
            end

            if (state != S_ARMED) begin
                armed_cnt <= '0;
            end else if (kept) begin
                armed_cnt <= armed_cnt + TO_W'(1);
            end

            if (fire) begin
                trig_ptr  <= wr_ptr;
                trig_real <= edge_hit;
            end
        end
    end

    // Bank swap and frame status on completion
    always_ff @(posedge clock) begin
        if (reset) begin
            front_sel   <= 1'b0;
            start_front <= '0;
            frame_valid <= 1'b0;
            triggered   <= 1'b0;
        end else if (state == S_DONE) begin
            front_sel   <= ~front_sel;
            start_front <= new_start;
            frame_valid <= 1'b1;
            triggered   <= trig_real;
        end
    end

    // Back-bank write of each kept sample
    always_ff @(posedge clock) begin
        // NOTE: the sample buffer has no reset; its contents only matter once a frame has been written.
        if (kept) begin
            mem[~front_sel][IDX_W'(wr_ptr)] <= ch_data;
        end
    end

    // During DONE the read already targets the bank and offset that become front
    always_comb begin
        rd_sel   = (state == S_DONE) ? ~front_sel : front_sel;
        rd_start = (state == S_DONE) ? new_start : start_front;
        rd_sum   = {1'b0, rd_start} + {1'b0, rd_addr};
        rd_phys  = ADDR_W'((rd_sum >= DEPTH_L) ? (rd_sum - DEPTH_L) : rd_sum);
    end

    // Registered front-bank readout by screen X
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} >= DEPTH_L) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_sel][IDX_W'(rd_phys)];
        end
    end

endmodule

// File: doc/scope_capture.md
# scope_capture

Parametrised N-channel triggered capture engine for the oscilloscope datapath, successor to the free-running per-channel sampler. It sits between the ADC channel outputs and the VGA renderer. It decimates the incoming samples and waits for a level/edge trigger on a selectable channel. It then captures a full screen-width frame with programmable pre-trigger depth into a ping-pong buffer, so the renderer reads a stable, trigger-aligned frame by screen X.

## Interface
- CHANNELS, 2, number of captured channels (1..8)
- DATA_W, 12, sample width per channel
- DEPTH, 640, samples per frame (screen width)
- ADDR_W, 10, index width, 2^ADDR_W >= DEPTH
- DECIM_W, 16, decimation counter width
- AUTO_TIMEOUT, 2048, kept samples without trigger before auto mode forces one

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe, ch_data valid
- ch_data  in  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- trig_channel  in  3  trigger source channel; values >= CHANNELS select channel 0
- trig_level  in  DATA_W  unsigned trigger threshold
- trig_falling  in  1  0 = rising edge, 1 = falling edge
- mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal
- arm  in  1  start capture from IDLE
- decim  in  DECIM_W  keep 1 of every decim+1 valid samples
- pretrig  in  ADDR_W  samples shown before trigger point
- rd_addr  in  ADDR_W  screen X
- rd_data  out  CHANNELS*DATA_W  front-bank sample at rd_addr
- frame_ready  out  1  one-cycle pulse on bank swap
- frame_valid  out  1  front bank holds a completed frame
- triggered  out  1  last completed frame had a real trigger (0 = auto-forced)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PREFILL, ARMED, POST, DONE.
- Control is latched on leaving IDLE or DONE: trig_channel, trig_level, trig_falling, decim, pretrig and mode. pretrig >= DEPTH clamps to DEPTH-1.
- Decimation: a counter counts sample_valid strobes. A strobe is "kept" when the counter is 0; the counter wraps to 0 after reaching decim. decim=0 keeps every strobe.
- Every kept sample in PREFILL, ARMED and POST is written to the back bank at wr_ptr. wr_ptr increments modulo DEPTH.
- IDLE -> PREFILL on arm. If latched pretrig=0, go directly to ARMED.
- PREFILL -> ARMED after pretrig kept samples.
- Trigger is evaluated on each kept sample in ARMED, using the previous kept sample of the trigger channel (prev) and the current one (cur):
  - Rising: prev < level and cur >= level.
  - Falling: prev >= level and cur < level.
  - prev is invalid at PREFILL/ARMED entry, so the first kept sample never triggers.
- Auto mode: the ARMED kept-sample count reaching AUTO_TIMEOUT forces a trigger on that sample. A real edge on the same sample wins, so that frame reports triggered=1.
- On trigger: trig_ptr <= wr_ptr of the trigger sample; go to POST. POST writes DEPTH-pretrig kept samples, counting the trigger sample itself.
- DONE (1 cycle) performs these actions:
  - Swap banks.
  - start_front <= (trig_ptr - pretrig) mod DEPTH.
  - Pulse frame_ready; set frame_valid; update triggered.
- From DONE: single mode -> IDLE; auto/normal -> PREFILL (or ARMED if pretrig=0), decimation counter and wr_ptr reset to 0.
- arm outside IDLE is ignored. Control inputs changing mid-frame take effect at next latch.
- Readout: physical address = (start_front + rd_addr) mod DEPTH. rd_addr >= DEPTH returns 0.

## Timing
- rd_data is registered, with latency 1 from rd_addr. It reads from the new bank starting the cycle after frame_ready.
- The back-bank write occurs in the same cycle as the kept sample_valid.
- The final POST sample is written in cycle T. DONE occurs at T+1, frame_ready is high during T+1, and rd_data reflects the new bank for addresses presented from T+1.
- sample_valid during DONE is dropped. Upstream strobes are at most one every 2 cycles.
- Reset values:
  - State IDLE.
  - frame_ready, frame_valid, triggered, busy and rd_data are 0.
  - Bank select, pointers and counters are 0.
  - Buffer contents are not reset.
- Reset mid-capture abandons the frame. The front bank is declared invalid via frame_valid=0.

## Test plan
- Normal, rising, DEPTH=16, pretrig=4, decim=0, level=100, ramp ch0 0,10,20… on every other cycle, arm -> trigger at sample value 100; rd_addr 0..15 returns 60,70,…,210; triggered=1; frame_ready pulses once.
- decim=2, same ramp -> frame data steps by 30. The trigger is the first kept sample >=100, value 120, at rd_addr 4.
- Auto mode, AUTO_TIMEOUT=8, constant input 50 -> frame completes after 4+8+11 kept samples (trigger is the 8th ARMED sample), triggered=0, frame_valid=1, then re-arms automatically.
- Single mode, falling edge, level=500, square 0/1000 -> exactly one frame_ready. Then busy=0 and further edges are ignored until arm is asserted again.
- pretrig=20 with DEPTH=16 -> clamps to 15. The trigger sample appears at rd_addr 15; the frame holds 1 post sample.
- Reset asserted during POST -> next cycle busy=0, frame_valid=0, rd_data=0. A new arm yields a correct frame.
